// File: rtl/uart_cmd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_cmd_pkg
//  Description : Shared definitions for the UART command framer: FSM state
//                encoding, default frame header, error codes, the config
//                register address map and the frame checksum helper.
//  Revision    : 1.0  initial release
// ============================================================================
package uart_cmd_pkg;

  // One-hot framer states
  typedef enum logic [5:0] {
    ST_IDLE  = 6'b000001,
    ST_ADDR  = 6'b000010,
    ST_DH    = 6'b000100,
    ST_DL    = 6'b001000,
    ST_CHK   = 6'b010000,
    ST_ISSUE = 6'b100000
  } state_e;

  localparam logic [7:0] HEADER_DEF   = 8'hAA;
  localparam int         NUM_REGS_DEF = 8;

  // err_code values
  localparam logic [1:0] ERR_CHK  = 2'd1;
  localparam logic [1:0] ERR_TO   = 2'd2;
  localparam logic [1:0] ERR_ADDR = 2'd3;

  // Config register bank address map
  localparam logic [7:0] REG_FFT_LEN    = 8'h00;
  localparam logic [7:0] REG_WINDOW_SEL = 8'h01;
  localparam logic [7:0] REG_GAIN       = 8'h02;
  localparam logic [7:0] REG_TRIG_LEVEL = 8'h03;
  localparam logic [7:0] REG_TRIG_MODE  = 8'h04;
  localparam logic [7:0] REG_AVG_COUNT  = 8'h05;
  localparam logic [7:0] REG_DECIMATE   = 8'h06;
  localparam logic [7:0] REG_CTRL       = 8'h07;

  // Frame checksum: XOR of the three payload bytes
  function automatic logic [7:0] frame_chk(input logic [7:0] addr,
                                           input logic [7:0] data_h,
                                           input logic [7:0] data_l);
    return addr ^ data_h ^ data_l;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_frame_timer.sv
`default_nettype none
// ============================================================================
//  Module      : uart_frame_timer
//  Description : Inter-byte gap counter. Counts while enabled, returns to 0
//                on clear or when disabled, and flags expiry when the count
//                sits at TO_CYC-1 with no clear in the same cycle.
//  Ports       : sys_clk   - clock
//                sys_rst_n - asynchronous active-low reset
//                clr_i     - restart the count (byte received)
//                en_i      - count enable (frame in progress)
//                expire_o  - combinational expiry flag
//  Revision    : 1.0  initial release
// ============================================================================
module uart_frame_timer #(
  parameter int TO_CYC = 100
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int             c_w    = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;
  localparam logic [c_w-1:0] c_last = c_w'(TO_CYC - 1);

  logic [c_w-1:0] cnt_q;
  logic [c_w-1:0] cnt_d;

  // A clear in the expiry cycle means a byte arrived in time.
  assign expire_o = en_i && !clr_i && (cnt_q == c_last);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || !en_i) begin
      cnt_d = '0;
    end else if (cnt_q != c_last) begin
      cnt_d = cnt_q + c_w'(1);
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_cmd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : uart_cmd_ctrl
//  Description : Frames UART RX bytes (HEADER, ADDR, DATA_H, DATA_L, CHK)
//                into config register writes. Rejects frames with a bad
//                checksum, out-of-range address or inter-byte timeout, and
//                holds the write off while the config target is busy.
//  Ports       : sys_clk, sys_rst_n    - clock, async active-low reset
//                rx_valid, rx_byte     - received byte strobe and value
//                cfg_busy              - config target not ready
//                cfg_wr_en             - one-cycle write strobe
//                cfg_addr, cfg_wdata   - write address / data (held)
//                frame_ok, frame_err   - good / rejected frame pulses
//                err_code              - reject reason (held)
//                frame_cnt             - good frame count (wraps)
//  Revision    : 1.0  initial release
// ============================================================================
module uart_cmd_ctrl
  import uart_cmd_pkg::*;
#(
  parameter int         CLK_FRE    = 50,
  parameter int         TIMEOUT_US = 1000,
  parameter logic [7:0] HEADER     = HEADER_DEF,
  parameter int         NUM_REGS   = NUM_REGS_DEF
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        rx_valid,
  input  logic [7:0]  rx_byte,
  input  logic        cfg_busy,
  output logic        cfg_wr_en,
  output logic [7:0]  cfg_addr,
  output logic [15:0] cfg_wdata,
  output logic        frame_ok,
  output logic        frame_err,
  output logic [1:0]  err_code,
  output logic [15:0] frame_cnt
);

  localparam int         c_to_cyc   = CLK_FRE * TIMEOUT_US;
  // 9 bits so that NUM_REGS=256 (every address valid) is representable
  localparam logic [8:0] c_num_regs = 9'(NUM_REGS);

  state_e      state_q, state_d;
  logic [7:0]  addr_q, addr_d;
  logic [7:0]  dh_q, dh_d;
  logic [7:0]  dl_q, dl_d;
  logic        wr_en_q, wr_en_d;
  logic [7:0]  cfg_addr_q, cfg_addr_d;
  logic [15:0] cfg_wdata_q, cfg_wdata_d;
  logic        ok_q, ok_d;
  logic        err_q, err_d;
  logic [1:0]  err_code_q, err_code_d;
  logic [15:0] cnt_q, cnt_d;

  logic        timer_en;
  logic        timer_expire;

  assign timer_en = (state_q == ST_ADDR) || (state_q == ST_DH) ||
                    (state_q == ST_DL)   || (state_q == ST_CHK);

  uart_frame_timer #(
    .TO_CYC (c_to_cyc)
  ) u_timer (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .clr_i     (rx_valid),
    .en_i      (timer_en),
    .expire_o  (timer_expire)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    dh_d        = dh_q;
    dl_d        = dl_q;
    wr_en_d     = 1'b0;
    ok_d        = 1'b0;
    err_d       = 1'b0;
    err_code_d  = err_code_q;
    cfg_addr_d  = cfg_addr_q;
    cfg_wdata_d = cfg_wdata_q;
    cnt_d       = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (rx_valid && (rx_byte == HEADER)) begin
          state_d = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (rx_valid) begin
          addr_d  = rx_byte;
          state_d = ST_DH;
        end else if (timer_expire) begin
          err_d      = 1'b1;
          err_code_d = ERR_TO;
          state_d    = ST_IDLE;
        end
      end
      ST_DH: begin
        if (rx_valid) begin
          dh_d    = rx_byte;
          state_d = ST_DL;
        end else if (timer_expire) begin
          err_d      = 1'b1;
          err_code_d = ERR_TO;
          state_d    = ST_IDLE;
        end
      end
      ST_DL: begin
        if (rx_valid) begin
          dl_d    = rx_byte;
          state_d = ST_CHK;
        end else if (timer_expire) begin
          err_d      = 1'b1;
          err_code_d = ERR_TO;
          state_d    = ST_IDLE;
        end
      end
      ST_CHK: begin
        if (rx_valid) begin
          if (rx_byte != frame_chk(addr_q, dh_q, dl_q)) begin
            err_d      = 1'b1;
            err_code_d = ERR_CHK;
            state_d    = ST_IDLE;
          end else if ({1'b0, addr_q} >= c_num_regs) begin
            err_d      = 1'b1;
            err_code_d = ERR_ADDR;
            state_d    = ST_IDLE;
          end else begin
            state_d = ST_ISSUE;
          end
        end else if (timer_expire) begin
          err_d      = 1'b1;
          err_code_d = ERR_TO;
          state_d    = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        // Incoming bytes are ignored here, including HEADER.
        if (!cfg_busy) begin
          wr_en_d     = 1'b1;
          ok_d        = 1'b1;
          cfg_addr_d  = addr_q;
          cfg_wdata_d = {dh_q, dl_q};
          cnt_d       = cnt_q + 16'd1;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      dh_q        <= '0;
      dl_q        <= '0;
      wr_en_q     <= 1'b0;
      cfg_addr_q  <= '0;
      cfg_wdata_q <= '0;
      ok_q        <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      dh_q        <= dh_d;
      dl_q        <= dl_d;
      wr_en_q     <= wr_en_d;
      cfg_addr_q  <= cfg_addr_d;
      cfg_wdata_q <= cfg_wdata_d;
      ok_q        <= ok_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
      cnt_q       <= cnt_d;
    end
  end

  assign cfg_wr_en = wr_en_q;
  assign cfg_addr  = cfg_addr_q;
  assign cfg_wdata = cfg_wdata_q;
  assign frame_ok  = ok_q;
  assign frame_err = err_q;
  assign err_code  = err_code_q;
  assign frame_cnt = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_cmd_ctrl
//  Description : Self-checking bench for uart_cmd_ctrl. Expected write and
//                error events are queued as frames are sent and compared
//                against the DUT output pulses, including cycle windows.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_cmd_ctrl;

  logic        sys_clk;
  logic        sys_rst_n;
  logic        rx_valid;
  logic [7:0]  rx_byte;
  logic        cfg_busy;
  logic        cfg_wr_en;
  logic [7:0]  cfg_addr;
  logic [15:0] cfg_wdata;
  logic        frame_ok;
  logic        frame_err;
  logic [1:0]  err_code;
  logic [15:0] frame_cnt;

  uart_cmd_ctrl #(
    .CLK_FRE    (50),
    .TIMEOUT_US (2),
    .HEADER     (8'hAA),
    .NUM_REGS   (8)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .rx_valid  (rx_valid),
    .rx_byte   (rx_byte),
    .cfg_busy  (cfg_busy),
    .cfg_wr_en (cfg_wr_en),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .frame_ok  (frame_ok),
    .frame_err (frame_err),
    .err_code  (err_code),
    .frame_cnt (frame_cnt)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    bit          is_wr;
    logic [7:0]  addr;
    logic [15:0] data;
    logic [1:0]  code;
    int          lo;
    int          hi;
  } exp_t;

  exp_t sb[$];
  int   exp_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  task automatic push_wr(input logic [7:0] a, input logic [15:0] d, input int lo, input int hi);
    exp_t e;
    e.is_wr = 1'b1; e.addr = a; e.data = d; e.code = 2'd0; e.lo = lo; e.hi = hi;
    sb.push_back(e);
    exp_cnt++;
  endtask

  task automatic push_err(input logic [1:0] c, input int lo, input int hi);
    exp_t e;
    e.is_wr = 1'b0; e.addr = 8'h0; e.data = 16'h0; e.code = c; e.lo = lo; e.hi = hi;
    sb.push_back(e);
  endtask

  // Output monitor: every strobe must match the head of the scoreboard.
  always @(negedge sys_clk) begin
    if (sys_rst_n && (cfg_wr_en || frame_ok || frame_err)) begin
      if (sb.size() == 0) begin
        check("unexpected_strobe", {29'd0, cfg_wr_en, frame_ok, frame_err}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("strobe_cycle_in_window", (cyc >= e.lo && cyc <= e.hi) ? 32'd1 : 32'd0, 32'd1);
        if (e.is_wr) begin
          check("cfg_wr_en", cfg_wr_en, 1);
          check("frame_ok", frame_ok, 1);
          check("frame_err_quiet", frame_err, 0);
          check("cfg_addr", cfg_addr, e.addr);
          check("cfg_wdata", cfg_wdata, e.data);
        end else begin
          check("frame_err", frame_err, 1);
          check("wr_en_quiet", cfg_wr_en, 0);
          check("frame_ok_quiet", frame_ok, 0);
          check("err_code", err_code, e.code);
        end
      end
    end
  end

  // Drive one byte for one cycle; t is the cycle the strobe is present.
  task automatic send_byte(input logic [7:0] b, output int t);
    @(posedge sys_clk); #1;
    rx_valid = 1'b1;
    rx_byte  = b;
    t        = cyc;
    @(posedge sys_clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] h, input logic [7:0] l,
                            input logic [7:0] c, output int tchk);
    int t;
    send_byte(8'hAA, t);
    send_byte(a, t);
    send_byte(h, t);
    send_byte(l, t);
    send_byte(c, tchk);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  initial begin
    int t;
    sys_rst_n = 1'b0;
    rx_valid  = 1'b0;
    rx_byte   = 8'h00;
    cfg_busy  = 1'b0;

    // Reset state
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    check("rst_wr_en", cfg_wr_en, 0);
    check("rst_addr", cfg_addr, 0);
    check("rst_wdata", cfg_wdata, 0);
    check("rst_ok_err", {frame_ok, frame_err}, 0);
    check("rst_err_code", err_code, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    @(posedge sys_clk); #1;
    sys_rst_n = 1'b1;
    idle(2);

    // 1: good frame, write two cycles after the checksum strobe
    send_frame(8'h03, 8'h12, 8'h34, 8'h25, t);
    push_wr(8'h03, 16'h1234, t + 2, t + 2);
    idle(5);
    check("cnt_after_t1", frame_cnt, exp_cnt);

    // 2: checksum error, outputs held
    send_frame(8'h03, 8'h12, 8'h34, 8'h26, t);
    push_err(2'd1, t + 1, t + 1);
    idle(5);
    check("cnt_after_t2", frame_cnt, exp_cnt);
    check("err_code_held_t2", err_code, 1);
    check("addr_held_t2", cfg_addr, 8'h03);
    check("wdata_held_t2", cfg_wdata, 16'h1234);

    // 3: address out of range
    send_frame(8'h09, 8'h00, 8'h01, 8'h08, t);
    push_err(2'd3, t + 1, t + 1);
    idle(5);
    check("cnt_after_t3", frame_cnt, exp_cnt);

    // 4: inter-byte timeout, then a following good frame
    send_byte(8'hAA, t);
    send_byte(8'h01, t);
    push_err(2'd2, t + 100, t + 101);
    idle(110);
    send_frame(8'h01, 8'h00, 8'h05, 8'h04, t);
    push_wr(8'h01, 16'h0005, t + 2, t + 2);
    idle(5);
    check("cnt_after_t4", frame_cnt, exp_cnt);

    // 4b: byte arriving exactly in the expiry cycle is accepted
    send_byte(8'hAA, t);
    send_byte(8'h06, t);
    begin
      int target;
      target = t + 100;
      while (cyc < target - 1) begin
        @(posedge sys_clk); #1;
      end
      send_byte(8'h77, t);
      check("boundary_byte_cycle", t, target);
    end
    send_byte(8'h88, t);
    send_byte(8'hF9, t);
    push_wr(8'h06, 16'h7788, t + 2, t + 2);
    idle(5);
    check("cnt_after_boundary", frame_cnt, exp_cnt);

    // 5: busy target; bytes during the wait are dropped
    cfg_busy = 1'b1;
    send_frame(8'h02, 8'h0F, 8'hF0, 8'hFD, t);
    send_byte(8'h55, t);
    send_byte(8'hAA, t);
    idle(16);
    cfg_busy = 1'b0;
    push_wr(8'h02, 16'h0FF0, cyc + 1, cyc + 2);
    idle(5);
    check("cnt_after_t5", frame_cnt, exp_cnt);

    // 6: leading garbage then a good frame
    send_byte(8'h00, t);
    send_byte(8'hFF, t);
    send_frame(8'h04, 8'h00, 8'h10, 8'h14, t);
    push_wr(8'h04, 16'h0010, t + 2, t + 2);
    idle(5);
    check("cnt_after_t6", frame_cnt, exp_cnt);

    // 6b: reset mid-frame discards the partial frame
    send_byte(8'hAA, t);
    send_byte(8'h02, t);
    send_byte(8'h11, t);
    sys_rst_n = 1'b0;
    exp_cnt   = 0;
    @(negedge sys_clk);
    check("midrst_addr", cfg_addr, 0);
    check("midrst_wdata", cfg_wdata, 0);
    check("midrst_cnt", frame_cnt, 0);
    check("midrst_err_code", err_code, 0);
    @(posedge sys_clk); #1;
    sys_rst_n = 1'b1;
    idle(2);
    send_frame(8'h05, 8'hAB, 8'hCD, 8'h63, t);
    push_wr(8'h05, 16'hABCD, t + 2, t + 2);
    idle(5);
    check("cnt_after_rst", frame_cnt, exp_cnt);

    idle(10);
    check("scoreboard_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d, expected end before 20000", cyc);
    $fatal(1);
  end

endmodule
`default_nettype wire
